// File: rtl/mba_pkg.sv
// Shared types and helpers for the iterative radix-4 Modified Booth multiplier.
package mba_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    // One recoded Booth digit: magnitude one/two, negated when neg is set.
    typedef struct packed {
        logic neg;
        logic two;
        logic one;
    } booth_t;

    // Window is {b[2k+1], b[2k], b[2k-1]}; 000 and 111 both recode to zero.
    function automatic booth_t booth_encode(input logic [2:0] win);
        booth_t d;
        d.neg = win[2] & ~(win[1] & win[0]);
        d.one = win[1] ^ win[0];
        d.two = (win == 3'b011) || (win == 3'b100);
        return d;
    endfunction

    // Unsigned operands carry two zero MSBs, which needs one extra digit.
    function automatic int num_digits(input int w, input logic sgn);
        return sgn ? (w / 2) : (w / 2 + 1);
    endfunction

endpackage

// File: rtl/mba_r4_pp.sv
// Booth digit recoder and partial-product selector: pp = d * a_ext, d in {-2..+2}.
module mba_r4_pp
    import mba_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [2:0]   win,
    input  logic [W+1:0] a_ext,
    output logic [W+2:0] pp
);

    booth_t       dig;
    logic [W+2:0] a_sx;
    logic [W+2:0] mag;

    assign dig = booth_encode(win);

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        a_sx = {a_ext[W+1], a_ext};
        mag  = '0;
        if (dig.two) begin
            mag = {a_ext, 1'b0};
        end else if (dig.one) begin
            mag = a_sx;
        end
        pp = dig.neg ? -mag : mag;
    end

endmodule

// File: rtl/mba_r4_seq.sv
// Iterative radix-4 Modified Booth multiplier, one digit per clock, valid/ready on both sides.
// Optional `MBA_R4_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are uniform.
module mba_r4_seq
    import mba_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           sgn,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] p,
    output logic           busy
);

    localparam int AW = 2 * W + 2;
    localparam int CW = $clog2(W / 2 + 2);

    state_t         state_q, state_d;
    logic [W+1:0]   a_q, a_d;
    logic [W+2:0]   b_q, b_d;
    logic [AW-1:0]  acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           sgn_q, sgn_d;
    logic [2*W-1:0] p_q, p_d;
    logic           out_valid_q, out_valid_d;
    logic           in_ready_q, in_ready_d;

    logic [W+2:0]   pp;
    logic [AW-1:0]  pp_sh;
    logic [W+2:0]   b_shift;
    logic [CW-1:0]  cnt_inc;
    logic           run_last;
    logic           accept;

    // b_q holds {b_ext, b[-1]} and shifts right two bits per digit, so the window is always b_q[2:0].
    mba_r4_pp #(.W(W)) u_pp (
        .win   (b_q[2:0]),
        .a_ext (a_q),
        .pp    (pp)
    );

    assign accept  = in_valid & in_ready_q;
    assign cnt_inc = cnt_q + CW'(1);
    assign b_shift = {{2{b_q[W+2]}}, b_q[W+2:2]};
    assign pp_sh   = {{(W-1){pp[W+2]}}, pp} << {cnt_q, 1'b0};

`ifdef MBA_R4_EARLY_EXIT_EN
    // Uniform remaining bits recode to all-zero digits, so the accumulator is already final.
    assign run_last = (cnt_inc == CW'(num_digits(W, sgn_q))) || (b_shift == '0) || (&b_shift);
`else
    assign run_last = (cnt_inc == CW'(num_digits(W, sgn_q)));
`endif

    // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            sgn_q       <= 1'b0;
            p_q         <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sgn_q       <= sgn_d;
            p_q         <= p_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)    state_d = ST_RUN;
            ST_RUN:  if (run_last)  state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sgn_d       = sgn_q;
        p_d         = p_q;
        out_valid_d = out_valid_q;
        in_ready_d  = (state_d == ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d   = sgn ? {{2{a[W-1]}}, a} : {2'b00, a};
                    b_d   = {(sgn ? {2{b[W-1]}} : 2'b00), b, 1'b0};
                    acc_d = '0;
                    cnt_d = '0;
                    sgn_d = sgn;
                end
            end
            ST_RUN: begin
                acc_d = acc_q + pp_sh;
                cnt_d = cnt_inc;
                b_d   = b_shift;
                if (run_last) begin
                    p_d         = acc_d[2*W-1:0];
                    out_valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) out_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready  = in_ready_q;
        out_valid = out_valid_q;
        p         = p_q;
        busy      = (state_q == ST_RUN);
    end

endmodule

// File: tb/tb_mba_r4_seq.sv
// Directed and randomised bench for mba_r4_seq at W=8, 12 and 16 sharing one clock and reset.
module tb_mba_r4_seq;

`ifdef MBA_R4_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  in_valid;
    logic [2:0]  in_ready;
    logic [2:0]  out_valid;
    logic [2:0]  busy;
    logic        sgn;
    logic        out_ready;
    logic [15:0] a_bus;
    logic [15:0] b_bus;
    logic [15:0] p8;
    logic [23:0] p12;
    logic [31:0] p16;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mba_r4_seq #(.W(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .sgn(sgn),
        .a(a_bus[7:0]), .b(b_bus[7:0]), .out_valid(out_valid[0]), .out_ready(out_ready),
        .p(p8), .busy(busy[0])
    );

    mba_r4_seq #(.W(12)) u_dut12 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .sgn(sgn),
        .a(a_bus[11:0]), .b(b_bus[11:0]), .out_valid(out_valid[1]), .out_ready(out_ready),
        .p(p12), .busy(busy[1])
    );

    mba_r4_seq #(.W(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .sgn(sgn),
        .a(a_bus), .b(b_bus), .out_valid(out_valid[2]), .out_ready(out_ready),
        .p(p16), .busy(busy[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int width_of(input int k);
        return (k == 0) ? 8 : ((k == 1) ? 12 : 16);
    endfunction

    function automatic logic [31:0] p_of(input int k);
        case (k)
            0:       return {16'h0, p8};
            1:       return {8'h0, p12};
            default: return p16;
        endcase
    endfunction

    // Exact product of the low w bits of a and b, reduced to 2w bits.
    function automatic logic [31:0] ref_mul(input int w, input logic s,
                                            input logic [15:0] a, input logic [15:0] b);
        longint av, bv, pr;
        av = longint'(a) & ((longint'(1) << w) - 1);
        bv = longint'(b) & ((longint'(1) << w) - 1);
        if (s && a[w-1]) av = av - (longint'(1) << w);
        if (s && b[w-1]) bv = bv - (longint'(1) << w);
        pr = av * bv;
        return 32'(pr & ((longint'(1) << (2 * w)) - 1));
    endfunction

    // Cycles from accept to out_valid; with early exit, the first k whose bits b[w+1:2k-1] agree.
    function automatic int exp_lat(input int w, input logic s, input logic [15:0] b);
        int         n;
        logic [17:0] bx;
        bit          uni;
        n  = s ? (w / 2) : (w / 2 + 1);
        bx = '0;
        for (int i = 0; i < w; i++) bx[i] = b[i];
        bx[w]   = s & b[w-1];
        bx[w+1] = s & b[w-1];
        if (EARLY_EXIT) begin
            for (int k = 1; k < n; k++) begin
                uni = 1'b1;
                for (int i = 2 * k - 1; i <= w + 1; i++) if (bx[i] != bx[w+1]) uni = 1'b0;
                if (uni) return k;
            end
        end
        return n;
    endfunction

    // One transaction on DUT k: accept, measure latency, hold for `hold` cycles, then handshake.
    task automatic run_txn(input string tag, input int k, input logic s,
                           input logic [15:0] av, input logic [15:0] bv,
                           input int hold, input logic [31:0] p_exp, input int lat_exp);
        int guard;
        int lat;
        guard = 0;
        while (!in_ready[k] && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "/in_ready"}, 32'(in_ready[k]), 32'd1);
        a_bus       = av;
        b_bus       = bv;
        sgn         = s;
        in_valid[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[k] = 1'b0;
        lat = 0;
        while (!out_valid[k] && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, "/latency"}, 32'(lat), 32'(lat_exp));
        check({tag, "/p"}, p_of(k), p_exp);
        for (int i = 0; i < hold; i++) begin
            a_bus       = ~av;
            b_bus       = bv ^ 16'h00a5;
            in_valid[k] = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check({tag, "/hold_p"}, p_of(k), p_exp);
            check({tag, "/hold_valid"}, 32'(out_valid[k]), 32'd1);
            check({tag, "/hold_in_ready"}, 32'(in_ready[k]), 32'd0);
        end
        in_valid[k] = 1'b0;
        out_ready   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "/post_valid"}, 32'(out_valid[k]), 32'd0);
        check({tag, "/post_in_ready"}, 32'(in_ready[k]), 32'd1);
        check({tag, "/post_p"}, p_of(k), p_exp);
    endtask

    initial begin
        int          k;
        logic        s;
        logic [15:0] ra, rb;
        int          w;

        in_valid  = '0;
        out_ready = 1'b0;
        sgn       = 1'b0;
        a_bus     = '0;
        b_bus     = '0;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        check("reset/in_ready", 32'(in_ready), 32'd0);
        check("reset/out_valid", 32'(out_valid), 32'd0);
        check("reset/busy", 32'(busy), 32'd0);
        check("reset/p8", 32'(p8), 32'd0);
        check("reset/p16", p16, 32'd0);
        rst = 1'b0;
        #1;
        check("release/in_ready_low", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("release/in_ready_high", 32'(in_ready), 32'h7);

        run_txn("s8_min_min", 0, 1'b1, 16'h0080, 16'h0080, 0, 32'h4000, 4);
        run_txn("u8_ff_ff",   0, 1'b0, 16'h00ff, 16'h00ff, 1, 32'hfe01, 5);
        run_txn("s8_ff_ff",   0, 1'b1, 16'h00ff, 16'h00ff, 0, 32'h0001, EARLY_EXIT ? 1 : 4);
        run_txn("s8_hold",    0, 1'b1, 16'h0007, 16'h0003, 3, 32'h0015, EARLY_EXIT ? 2 : 4);

        // Abort a transaction in its second RUN cycle.
        @(negedge clk);
        a_bus       = 16'h0033;
        b_bus       = 16'h0055;
        sgn         = 1'b1;
        in_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort/busy_before", 32'(busy[0]), 32'd1);
        rst = 1'b1;
        #1;
        check("abort/out_valid", 32'(out_valid[0]), 32'd0);
        check("abort/p", 32'(p8), 32'd0);
        check("abort/busy", 32'(busy[0]), 32'd0);
        check("abort/in_ready", 32'(in_ready[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_txn("s8_after_rst", 0, 1'b1, 16'h00fb, 16'h0006, 0, 32'hffe2, EARLY_EXIT ? 2 : 4);
        run_txn("s16_min_max",  2, 1'b1, 16'h8000, 16'h7fff, 2, 32'hc0008000, 8);
        run_txn("u12_max_max",  1, 1'b0, 16'h0fff, 16'h0fff, 0, 32'h00ffe001, 7);
        run_txn("s8_zero_b",    0, 1'b1, 16'h005a, 16'h0000, 0, 32'h0000, EARLY_EXIT ? 1 : 4);
        run_txn("u8_zero_b",    0, 1'b0, 16'h005a, 16'h0000, 0, 32'h0000, EARLY_EXIT ? 1 : 5);

        for (int i = 0; i < 32; i++) begin
            k  = i % 2;
            w  = width_of(k);
            s  = 1'($urandom_range(0, 1));
            ra = 16'($urandom);
            rb = 16'($urandom);
            run_txn("rand", k, s, ra, rb, int'($urandom_range(0, 3)),
                    ref_mul(w, s, ra, rb), exp_lat(w, s, rb));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mba_r4_seq.md
# mba_r4_seq

Parametrised iterative radix-4 Modified Booth multiplier. Recodes one radix-4 digit of the multiplier per clock and accumulates the selected partial product, so one shared adder replaces a full carry-save array. Supports signed or unsigned operands per transaction, selectable operand width, and valid/ready handshakes on input and output. Sits in the arithmetic datapath wherever area matters more than single-cycle latency.

## Interface
- `W`, default 8: operand width; even, ≥ 4.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operands present.
- `in_ready`  out  1  block can accept; reset 0, then 1 from the first clock after reset deasserts.
- `sgn`  in  1  1 = both operands two's complement; 0 = both unsigned.
- `a`  in  W  multiplicand.
- `b`  in  W  multiplier (Booth-recoded).
- `out_valid`  out  1  product valid; reset 0.
- `out_ready`  in  1  consumer takes product.
- `p`  out  2W  product; reset 0.
- `busy`  out  1  state is RUN; reset 0.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- `in_ready` = (state == IDLE). Accept occurs on an edge with `in_valid & in_ready`.
- On accept:
  - Register `a` extended to W+2 bits: sign-extended if `sgn`, zero-extended otherwise.
  - Register `b` extended to W+2 bits the same way, with lookup bit b[-1] = 0.
  - Clear the accumulator (2W+2 bits) and digit counter `cnt`.
  - Latch `sgn`. Go to RUN.
- Digit count: N = W/2 if `sgn`; N = W/2+1 if unsigned. The extra digit absorbs the zero-extended MSB pair.
- Each RUN edge:
  - Recode digit d ∈ {−2, −1, 0, +1, +2} from (b[2cnt+1], b[2cnt], b[2cnt−1]).
  - acc += (d·a_ext) << 2cnt, modulo 2^(2W+2).
  - cnt += 1.
  - When cnt reaches N, go to DONE.
- Entering DONE: `p` ← acc[2W−1:0] and `out_valid` ← 1.
- In DONE, `p` and `out_valid` hold until an edge with `out_ready` = 1. That edge returns to IDLE and clears `out_valid`; `p` keeps its last value.
- `in_valid` is ignored outside IDLE. There is no back-to-back accept in DONE.
- Arithmetic:
  - The result equals the exact a×b, signed or unsigned per `sgn`, in 2W bits. Overflow cannot occur.
  - The (−2)·a case uses the W+2-bit extended operand, so the most negative `a` is exact.
- Reset asserted in any state aborts the transaction. All registers go to their reset values immediately, and the partial result is discarded.

## Timing
- Accept edge at cycle t. `out_valid` rises at edge t+N and stays high until the handshake.
- Fixed latency for W=8: 4 cycles signed, 5 cycles unsigned.
- Minimum initiation interval: N+2 cycles, with `out_ready` tied high.
- `out_valid` and `p` come directly from registers; there is no combinational path from inputs to outputs.
- `in_ready` depends only on state. It never depends combinationally on `in_valid`.

## Configuration
- `MBA_R4_EARLY_EXIT_EN`, when defined:
  - After each RUN edge, if all remaining multiplier bits b[W+1:2cnt−1] (after the cnt increment) are equal, go to DONE immediately.
  - The accumulator is already exact at that point, so `p` is correct.
  - RUN always lasts at least 1 cycle.
  - Latency is data-dependent, in the range 1..N.
- Undefined: latency is always exactly N, and the early-exit comparator is not synthesised.

## Structure
- Package `mba_pkg`:
  - State enum (IDLE/RUN/DONE).
  - Booth digit encoding: 3-bit {neg, two, one}.
  - Function returning N from W and `sgn`.
- Sub-module `mba_r4_pp`, combinational:
  - Inputs: 3-bit multiplier window and the W+2-bit multiplicand.
  - Output: W+3-bit signed partial product d·a.
  - It is the only recoding logic; the top level holds only the FSM, counter and accumulator.

## Test plan
- W=8, sgn=1, a=−128, b=−128: `p`=0x4000, `out_valid` exactly 4 cycles after accept.
- W=8, sgn=0, a=255, b=255: `p`=0xFE01 after 5 cycles. Same operands with sgn=1 give `p`=0x0001.
- W=8, sgn=1, a=7, b=3, `out_ready` held 0 for 3 cycles: `p`=0x0015 held stable, `in_ready`=0, and a new `in_valid` is ignored until the handshake. Latency is 4 cycles without the macro and 2 with `MBA_R4_EARLY_EXIT_EN`.
- `rst` pulsed at the second RUN cycle: `out_valid`=0, `p`=0, `busy`=0 immediately. The next transaction (−5 × 6) returns 0xFFE2.
- W=16, sgn=1, a=−32768, b=32767: `p`=0xC0008000 after 8 cycles.
- Randomised W=8 and W=12, both `sgn` values, random `out_ready` backpressure: every `p` matches a reference product. With the macro, a=0x5A, b=0 completes in 1 cycle with `p`=0.
